// File: rtl/nco_seq_pkg.sv
// -----------------------------------------------------------------------------
// nco_seq_pkg
// Shared definitions for the NCO tune sequencer: register-file addresses of the
// four phase-word bytes, the sequencer state encoding, the lock-timeout counter
// width and small helpers for byte selection and lock-address decoding.
// -----------------------------------------------------------------------------
package nco_seq_pkg;

    // Phase word bytes, MSB first; a write to the commit address latches the word.
    localparam logic [7:0] NCO_ADDR_B3     = 8'h00;
    localparam logic [7:0] NCO_ADDR_B2     = 8'h01;
    localparam logic [7:0] NCO_ADDR_B1     = 8'h02;
    localparam logic [7:0] NCO_ADDR_COMMIT = 8'h03;

    localparam int LOCK_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    // Byte idx of a tune word as it goes out on the burst: idx 0 carries [31:24].
    function automatic logic [7:0] tune_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    // Address of the next burst write after byte cnt.
    function automatic logic [7:0] burst_addr(input logic [1:0] idx);
        logic [7:0] a;
        case (idx)
            2'd0:    a = NCO_ADDR_B3;
            2'd1:    a = NCO_ADDR_B2;
            2'd2:    a = NCO_ADDR_B1;
            default: a = NCO_ADDR_COMMIT;
        endcase
        return a;
    endfunction

    // An I2C write to one of the pre-registers opens a partial phase word.
    function automatic logic is_partial_addr(input logic [7:0] addr);
        return (addr < NCO_ADDR_COMMIT);
    endfunction

endpackage

// File: rtl/nco_tune_sequencer_if.sv
// -----------------------------------------------------------------------------
// nco_tune_sequencer_if
// Bundles the I2C-slave write port, the tune request handshake and the
// register-file write port of the sequencer.
//   master : the sequencer (drives reg_*, tune_ready and status pulses)
//   slave  : the surroundings (I2C slave, tune source, register file)
// -----------------------------------------------------------------------------
interface nco_tune_sequencer_if;
    logic [7:0]  i2c_addr;
    logic [7:0]  i2c_data;
    logic        i2c_we;
    logic [31:0] tune_word;
    logic        tune_valid;
    logic        tune_ready;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        reg_we;
    logic        tune_done;
    logic        i2c_drop;
    logic        lock_expired;
    logic        busy;

    modport master (
        input  i2c_addr, i2c_data, i2c_we, tune_word, tune_valid,
        output tune_ready, reg_addr, reg_data, reg_we, tune_done,
               i2c_drop, lock_expired, busy
    );

    modport slave (
        output i2c_addr, i2c_data, i2c_we, tune_word, tune_valid,
        input  tune_ready, reg_addr, reg_data, reg_we, tune_done,
               i2c_drop, lock_expired, busy
    );
endinterface

// File: rtl/i2c_wr_buf.sv
// -----------------------------------------------------------------------------
// i2c_wr_buf
// One-entry holding buffer for an I2C write that cannot be issued right away.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push_i           an I2C write arrives that must be held
//   pop_i            the head entry is issued this cycle
//   addr_i, data_i   incoming write
//   valid_o          buffer holds a write
//   valid_next_o     buffer occupancy after this cycle
//   head_addr_o/data the entry to issue: a same-cycle push supersedes the
//                    stored one
//   drop_o           registered pulse when a held write is overwritten
// -----------------------------------------------------------------------------
module i2c_wr_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] data_i,
    output logic       valid_o,
    output logic       valid_next_o,
    output logic [7:0] head_addr_o,
    output logic [7:0] head_data_o,
    output logic       drop_o
);
    logic       valid_q, valid_d;
    logic       drop_q;
    logic [7:0] addr_q, data_q;

    // Occupancy: a pop consumes the head even when a push lands in the same cycle.
    always_comb begin
        valid_d = valid_q;
        if (pop_i) begin
            valid_d = 1'b0;
        end else if (push_i) begin
            valid_d = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage and overwrite detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            drop_q  <= push_i && valid_q;
            if (push_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end else begin
                addr_q <= addr_q;
                data_q <= data_q;
            end
        end
    end

    assign valid_o      = valid_q;
    assign valid_next_o = valid_d;
    assign head_addr_o  = push_i ? addr_i : addr_q;
    assign head_data_o  = push_i ? data_i : data_q;
    assign drop_o       = drop_q;

endmodule

// File: rtl/nco_tune_sequencer.sv
// -----------------------------------------------------------------------------
// nco_tune_sequencer
// Owns the register-file write port and arbitrates between the I2C slave and a
// local tune source. A tune request is written as an atomic 4-byte burst to
// 0x00..0x03 (MSB first); the 0x03 write commits the NCO phase word. I2C writes
// pass straight through when idle, otherwise wait in a one-entry buffer. A
// partially written I2C phase word locks out tune bursts until committed.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       nco_tune_sequencer_if.master: I2C write in, tune handshake,
//             register-file write out, status pulses and busy
// Parameter:
//   LOCK_TIMEOUT  cycles before a stale partial-write lock is dropped
// Optional feature macro: SEQ_LOCK_TIMEOUT_EN builds the lock timeout counter;
// without it lock_expired is constant 0 and the lock lasts until a 0x03 write.
// -----------------------------------------------------------------------------
module nco_tune_sequencer
    import nco_seq_pkg::*;
#(
    parameter logic [LOCK_CNT_W-1:0] LOCK_TIMEOUT = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    nco_tune_sequencer_if.master  bus
);
    seq_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        lock_q, lock_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  reg_data_q, reg_data_d;
    logic        reg_we_q, reg_we_d;
    logic        tune_done_q, tune_done_d;
    logic        busy_q, busy_d;
    logic        lock_expired_d;

    logic        tune_ready_s;
    logic        tune_hs_s;
    logic        issue_i2c_s;
    logic        buf_push_s, buf_pop_s;
    logic        buf_valid_s, buf_valid_next_s;
    logic [7:0]  buf_head_addr_s, buf_head_data_s;
    logic        i2c_drop_s;

    i2c_wr_buf u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (buf_push_s),
        .pop_i        (buf_pop_s),
        .addr_i       (bus.i2c_addr),
        .data_i       (bus.i2c_data),
        .valid_o      (buf_valid_s),
        .valid_next_o (buf_valid_next_s),
        .head_addr_o  (buf_head_addr_s),
        .head_data_o  (buf_head_data_s),
        .drop_o       (i2c_drop_s)
    );

    assign tune_ready_s = (state_q == IDLE) && !lock_q && !buf_valid_s && !rst;
    assign tune_hs_s    = bus.tune_valid && tune_ready_s;

    // Sequencer next state. Outputs are registered, so each branch prepares the
    // write that becomes visible on the following cycle; the DRAIN state is the
    // cycle on which the buffered write is visible.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        reg_we_d    = 1'b0;
        reg_addr_d  = bus.i2c_addr;   // idle: track the read address
        reg_data_d  = 8'h00;
        tune_done_d = 1'b0;
        buf_push_s  = 1'b0;
        buf_pop_s   = 1'b0;
        issue_i2c_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_valid_s) begin
                    // A write parked during DRAIN; a newer arrival supersedes it.
                    buf_push_s  = bus.i2c_we;
                    buf_pop_s   = 1'b1;
                    issue_i2c_s = 1'b1;
                    reg_we_d    = 1'b1;
                    reg_addr_d  = buf_head_addr_s;
                    reg_data_d  = buf_head_data_s;
                    state_d     = DRAIN;
                end else if (tune_hs_s) begin
                    buf_push_s  = bus.i2c_we;
                    word_d      = bus.tune_word;
                    cnt_d       = 2'd0;
                    reg_we_d    = 1'b1;
                    reg_addr_d  = burst_addr(2'd0);
                    reg_data_d  = tune_byte(bus.tune_word, 2'd0);
                    state_d     = BURST;
                end else if (bus.i2c_we) begin
                    issue_i2c_s = 1'b1;
                    reg_we_d    = 1'b1;
                    reg_addr_d  = bus.i2c_addr;
                    reg_data_d  = bus.i2c_data;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (cnt_q == 2'd3) begin
                    // An arrival on the commit cycle is drained right away too.
                    if (buf_valid_s || bus.i2c_we) begin
                        buf_push_s  = bus.i2c_we;
                        buf_pop_s   = 1'b1;
                        issue_i2c_s = 1'b1;
                        reg_we_d    = 1'b1;
                        reg_addr_d  = buf_head_addr_s;
                        reg_data_d  = buf_head_data_s;
                        state_d     = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    buf_push_s  = bus.i2c_we;
                    cnt_d       = cnt_q + 2'd1;
                    reg_we_d    = 1'b1;
                    reg_addr_d  = burst_addr(cnt_q + 2'd1);
                    reg_data_d  = tune_byte(word_q, cnt_q + 2'd1);
                    tune_done_d = (cnt_q == 2'd2);
                end
            end
            DRAIN: begin
                buf_push_s = bus.i2c_we;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SEQ_LOCK_TIMEOUT_EN
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_inc_s;
    logic                  lock_expired_q;

    assign lock_cnt_inc_s = lock_cnt_q + 16'd1;

    // Partial-write lock with stale-lock timeout; any issued I2C write restarts the count.
    always_comb begin
        lock_d         = lock_q;
        lock_cnt_d     = 16'd0;
        lock_expired_d = 1'b0;
        if (issue_i2c_s) begin
            if (is_partial_addr(reg_addr_d)) begin
                lock_d = 1'b1;
            end else if (reg_addr_d == NCO_ADDR_COMMIT) begin
                lock_d = 1'b0;
            end else begin
                lock_d = lock_q;
            end
        end else if (lock_q) begin
            if (lock_cnt_inc_s == LOCK_TIMEOUT) begin
                lock_d         = 1'b0;
                lock_expired_d = 1'b1;
            end else begin
                lock_cnt_d = lock_cnt_inc_s;
            end
        end else begin
            lock_d = lock_q;
        end
    end

    // Timeout counter and expiry pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt_q     <= 16'd0;
            lock_expired_q <= 1'b0;
        end else begin
            lock_cnt_q     <= lock_cnt_d;
            lock_expired_q <= lock_expired_d;
        end
    end

    assign bus.lock_expired = lock_expired_q;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^LOCK_TIMEOUT;

    // Partial-write lock: set by a pre-register write, cleared only by a commit write.
    always_comb begin
        lock_d         = lock_q;
        lock_expired_d = 1'b0;
        if (issue_i2c_s) begin
            if (is_partial_addr(reg_addr_d)) begin
                lock_d = 1'b1;
            end else if (reg_addr_d == NCO_ADDR_COMMIT) begin
                lock_d = 1'b0;
            end else begin
                lock_d = lock_q;
            end
        end else begin
            lock_d = lock_q;
        end
    end

    assign bus.lock_expired = lock_expired_d;
`endif

    // busy mirrors the state the sequencer is entering.
    assign busy_d = (state_d != IDLE) || lock_d || buf_valid_next_s;

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            word_q      <= 32'h0000_0000;
            lock_q      <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_data_q  <= 8'h00;
            reg_we_q    <= 1'b0;
            tune_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            lock_q      <= lock_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            reg_we_q    <= reg_we_d;
            tune_done_q <= tune_done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.tune_ready = tune_ready_s;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.reg_data   = reg_data_q;
    assign bus.reg_we     = reg_we_q;
    assign bus.tune_done  = tune_done_q;
    assign bus.i2c_drop   = i2c_drop_s;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_nco_tune_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nco_tune_sequencer
// Directed self-checking bench for nco_tune_sequencer. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge. Each sampled
// cycle is compared as a packed vector {reg_we, reg_addr, reg_data, tune_done,
// tune_ready, busy, i2c_drop} against hand-derived values. With
// SEQ_LOCK_TIMEOUT_EN defined the DUT runs with LOCK_TIMEOUT = 16.
// -----------------------------------------------------------------------------
module tb_nco_tune_sequencer;

`ifdef SEQ_LOCK_TIMEOUT_EN
    localparam logic [15:0] TB_TIMEOUT = 16'd16;
`else
    localparam logic [15:0] TB_TIMEOUT = 16'hFFFF;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nco_tune_sequencer_if bus ();

    nco_tune_sequencer #(.LOCK_TIMEOUT(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [20:0] pk(input logic we, input logic [7:0] a, input logic [7:0] d,
                                       input logic done, input logic rdy, input logic bsy,
                                       input logic drp);
        return {we, a, d, done, rdy, bsy, drp};
    endfunction

    function automatic logic [20:0] obs();
        return {bus.reg_we, bus.reg_addr, bus.reg_data, bus.tune_done,
                bus.tune_ready, bus.busy, bus.i2c_drop};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_i2c();
        bus.i2c_we   = 1'b0;
        bus.i2c_addr = 8'h00;
        bus.i2c_data = 8'h00;
    endtask

    task automatic drive_i2c(input logic [7:0] a, input logic [7:0] d);
        bus.i2c_we   = 1'b1;
        bus.i2c_addr = a;
        bus.i2c_data = d;
    endtask

    task automatic test_reset();
        idle_i2c();
        bus.tune_valid = 1'b0;
        bus.tune_word  = 32'h0000_0000;
        rst = 1'b1;
        #12;
        checks++;
        if (obs() !== pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0) || bus.lock_expired !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h lock_expired=%b", obs(),
                     pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), bus.lock_expired);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs(), pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        step();
    endtask

    task automatic test_passthrough();
        logic [20:0] exp_v [0:3];
        exp_v[0] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_v[1] = pk(1'b1, 8'h05, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_v[2] = pk(1'b0, 8'h42, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_v[3] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_i2c(8'h05, 8'h3C);
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_v[k]) begin
                failures++;
                $display("FAIL passthrough T+%0d got=%h exp=%h", k, obs(), exp_v[k]);
            end
            step();
            if (k == 0) begin
                bus.i2c_we   = 1'b0;
                bus.i2c_addr = 8'h42;
            end
            if (k == 1) idle_i2c();
        end
    endtask

    task automatic test_burst();
        logic [20:0] exp_v [0:6];
        exp_v[0] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_v[1] = pk(1'b1, 8'h00, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[2] = pk(1'b1, 8'h01, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[3] = pk(1'b1, 8'h02, 8'h56, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[4] = pk(1'b1, 8'h03, 8'h78, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_v[5] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_v[6] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.tune_word  = 32'h1234_5678;
        bus.tune_valid = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_v[k]) begin
                failures++;
                $display("FAIL burst T+%0d got=%h exp=%h", k, obs(), exp_v[k]);
            end
            step();
            if (k == 0) bus.tune_valid = 1'b0;
        end
    endtask

    task automatic test_same_cycle_i2c();
        logic [20:0] exp_v [0:6];
        exp_v[0] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_v[1] = pk(1'b1, 8'h00, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[2] = pk(1'b1, 8'h01, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[3] = pk(1'b1, 8'h02, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[4] = pk(1'b1, 8'h03, 8'hDD, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_v[5] = pk(1'b1, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[6] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.tune_word  = 32'hAABB_CCDD;
        bus.tune_valid = 1'b1;
        drive_i2c(8'h05, 8'hA5);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_v[k]) begin
                failures++;
                $display("FAIL same_cycle_i2c T+%0d got=%h exp=%h", k, obs(), exp_v[k]);
            end
            step();
            if (k == 0) begin
                bus.tune_valid = 1'b0;
                idle_i2c();
            end
        end
    endtask

    task automatic test_i2c_overwrite();
        logic [20:0] exp_v [0:6];
        exp_v[0] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_v[1] = pk(1'b1, 8'h00, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[2] = pk(1'b1, 8'h01, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[3] = pk(1'b1, 8'h02, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1);
        exp_v[4] = pk(1'b1, 8'h03, 8'hD4, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_v[5] = pk(1'b1, 8'h07, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[6] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.tune_word  = 32'hA1B2_C3D4;
        bus.tune_valid = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_v[k]) begin
                failures++;
                $display("FAIL i2c_overwrite T+%0d got=%h exp=%h", k, obs(), exp_v[k]);
            end
            step();
            if (k == 0) begin
                bus.tune_valid = 1'b0;
                drive_i2c(8'h04, 8'h11);
            end
            if (k == 1) drive_i2c(8'h07, 8'h22);
            if (k == 2) idle_i2c();
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] exp_v [0:10];
        exp_v[0]  = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_v[1]  = pk(1'b1, 8'h00, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[2]  = pk(1'b1, 8'h01, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[3]  = pk(1'b1, 8'h02, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[4]  = pk(1'b1, 8'h03, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_v[5]  = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_v[6]  = pk(1'b1, 8'h00, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[7]  = pk(1'b1, 8'h01, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[8]  = pk(1'b1, 8'h02, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[9]  = pk(1'b1, 8'h03, 8'h88, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_v[10] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.tune_word  = 32'h1122_3344;
        bus.tune_valid = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_v[k]) begin
                failures++;
                $display("FAIL back_to_back T+%0d got=%h exp=%h", k, obs(), exp_v[k]);
            end
            step();
            if (k == 0) bus.tune_word = 32'h5566_7788;
            if (k == 5) bus.tune_valid = 1'b0;
        end
    endtask

    task automatic test_lock();
        logic [20:0] exp_v [0:13];
        exp_v[0]  = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_v[1]  = pk(1'b1, 8'h00, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[2]  = pk(1'b1, 8'h01, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 3; k <= 7; k++) exp_v[k] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[8]  = pk(1'b1, 8'h03, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_v[9]  = pk(1'b1, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[10] = pk(1'b1, 8'h01, 8'h1E, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[11] = pk(1'b1, 8'h02, 8'h2D, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[12] = pk(1'b1, 8'h03, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_v[13] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_i2c(8'h00, 8'hAA);
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_v[k]) begin
                failures++;
                $display("FAIL lock_out T+%0d got=%h exp=%h", k, obs(), exp_v[k]);
            end
            step();
            if (k == 0) drive_i2c(8'h01, 8'hBB);
            if (k == 1) begin
                idle_i2c();
                bus.tune_word  = 32'h0F1E_2D3C;
                bus.tune_valid = 1'b1;
            end
            if (k == 6) drive_i2c(8'h03, 8'hCC);
            if (k == 7) idle_i2c();
            if (k == 8) bus.tune_valid = 1'b0;
        end
    endtask

`ifdef SEQ_LOCK_TIMEOUT_EN
    task automatic test_lock_timeout();
        logic [20:0] exp_o;
        logic        exp_x;
        drive_i2c(8'h02, 8'h77);
        for (int k = 0; k <= 18; k++) begin
            if (k == 0)       exp_o = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            else if (k == 1)  exp_o = pk(1'b1, 8'h02, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
            else if (k < 17)  exp_o = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            else              exp_o = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            exp_x = (k == 17);
            @(negedge clk);
            checks++;
            if (obs() !== exp_o || bus.lock_expired !== exp_x) begin
                failures++;
                $display("FAIL lock_timeout I+%0d got=%h exp=%h lock_expired=%b exp_expired=%b",
                         k - 1, obs(), exp_o, bus.lock_expired, exp_x);
            end
            step();
            if (k == 0) idle_i2c();
        end
    endtask
`else
    task automatic test_lock_persist();
        logic [20:0] exp_o;
        drive_i2c(8'h02, 8'h77);
        for (int k = 0; k <= 27; k++) begin
            if (k == 0)       exp_o = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            else if (k == 1)  exp_o = pk(1'b1, 8'h02, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
            else if (k < 27)  exp_o = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            else              exp_o = pk(1'b1, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (obs() !== exp_o || bus.lock_expired !== 1'b0) begin
                failures++;
                $display("FAIL lock_persist T+%0d got=%h exp=%h lock_expired=%b",
                         k, obs(), exp_o, bus.lock_expired);
            end
            step();
            if (k == 0)  idle_i2c();
            if (k == 25) drive_i2c(8'h03, 8'h00);
            if (k == 26) idle_i2c();
        end
    endtask
`endif

    task automatic test_reset_mid_burst();
        logic [20:0] exp_v [0:5];
        exp_v[0] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_v[1] = pk(1'b1, 8'h00, 8'hDE, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[2] = pk(1'b1, 8'h01, 8'hAD, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[3] = pk(1'b1, 8'h02, 8'hBE, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[4] = pk(1'b1, 8'h03, 8'hEF, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_v[5] = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.tune_word  = 32'h55AA_55AA;
        bus.tune_valid = 1'b1;
        step();
        bus.tune_valid = 1'b0;
        step();
        checks++;
        if (obs() !== pk(1'b1, 8'h01, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0)) begin
            failures++;
            $display("FAIL mid_burst_before_reset got=%h exp=%h", obs(),
                     pk(1'b1, 8'h01, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs() !== pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0) || bus.lock_expired !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h lock_expired=%b", obs(),
                     pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), bus.lock_expired);
        end
        step();
        rst = 1'b0;
        bus.tune_word  = 32'hDEAD_BEEF;
        bus.tune_valid = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_v[k]) begin
                failures++;
                $display("FAIL post_reset_burst T+%0d got=%h exp=%h", k, obs(), exp_v[k]);
            end
            step();
            if (k == 0) bus.tune_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_burst();
        test_same_cycle_i2c();
        test_i2c_overwrite();
        test_back_to_back();
        test_lock();
`ifdef SEQ_LOCK_TIMEOUT_EN
        test_lock_timeout();
`else
        test_lock_persist();
`endif
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
